// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared encodings and default vectors for the fetch sequencer
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EXC  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_JMP  = 2'd3
    } redir_src_e;

    localparam int          DEF_ADDR_W       = 11;
    localparam int          DEF_FIFO_DEPTH   = 8;
    localparam logic [10:0] DEF_RESET_VECTOR = 11'h000;
    localparam logic [10:0] DEF_EXC_VECTOR   = 11'h7F0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - redirect request / PC control / FIFO credit bundle
interface fetch_sequencer_if #(
    parameter int ADDR_W     = 11,
    parameter int FIFO_DEPTH = 8
);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    logic              exc_valid;
    logic              br_valid;
    logic [ADDR_W-1:0] br_target;
    logic              jmp_valid;
    logic [ADDR_W-1:0] jmp_target;
    logic              halt_req;
    logic              resume_req;
    logic              fifo_pop;
    logic              pc_branch_valid;
    logic [ADDR_W-1:0] pc_branch_address;
    logic              pc_hold;
    logic              fetch_en;
    logic              fifo_flush;
    logic [OCC_W-1:0]  occupancy;
    logic [1:0]        state;

    modport master (
        output exc_valid, br_valid, br_target, jmp_valid, jmp_target,
               halt_req, resume_req, fifo_pop,
        input  pc_branch_valid, pc_branch_address, pc_hold, fetch_en,
               fifo_flush, occupancy, state
    );

    modport slave (
        input  exc_valid, br_valid, br_target, jmp_valid, jmp_target,
               halt_req, resume_req, fifo_pop,
        output pc_branch_valid, pc_branch_address, pc_hold, fetch_en,
               fifo_flush, occupancy, state
    );
endinterface

// File: rtl/fetch_credit_cnt.sv
// rtl/fetch_credit_cnt.sv - fetch FIFO occupancy counter with flush clear and full/empty flags
module fetch_credit_cnt #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic up;
    logic dn;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign up    = inc && !full;
    assign dn    = dec && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (up && !dn) begin
            count <= count + 1'b1;
        end else if (dn && !up) begin
            count <= count - 1'b1;
        end
    end

    // A pop with nothing in the FIFO means the consumer lost track of credits.
    pop_underflow: assert property (@(posedge clk) disable iff (reset) !(dec && empty));

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC redirect arbiter and fetch phase FSM; FETCH_SEQ_PERF_EN adds perf counters
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_sequencer_if.slave      bus
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [15:0]           redirect_cnt,
    output logic [15:0]           stall_cnt
`endif
);
    seq_state_e        state_q;
    redir_src_e        src;
    logic [ADDR_W-1:0] tgt;
    logic              fetch_en;
    logic              flush_d;
    logic              credit_full;
    logic              credit_empty;

    // Priority exc > br > jmp; HALT only wakes on exc, BOOT takes nothing.
    always_comb begin
        src = SRC_NONE;
        tgt = '0;
        if (bus.exc_valid && state_q != ST_BOOT) begin
            src = SRC_EXC;
            tgt = EXC_VECTOR;
        end else if (bus.br_valid && (state_q == ST_RUN || state_q == ST_FLUSH)) begin
            src = SRC_BR;
            tgt = bus.br_target;
        end else if (bus.jmp_valid && (state_q == ST_RUN || state_q == ST_FLUSH)) begin
            src = SRC_JMP;
            tgt = bus.jmp_target;
        end
    end

    assign fetch_en    = (state_q == ST_RUN) && !credit_full;
    assign flush_d     = (state_q == ST_BOOT) || (src != SRC_NONE);
    assign bus.fetch_en = fetch_en;
    assign bus.pc_hold  = !fetch_en;
    assign bus.state    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q               <= ST_BOOT;
            bus.pc_branch_valid   <= 1'b0;
            bus.pc_branch_address <= '0;
            bus.fifo_flush        <= 1'b0;
        end else if (state_q == ST_BOOT) begin
            state_q               <= ST_FLUSH;
            bus.pc_branch_valid   <= 1'b1;
            bus.pc_branch_address <= RESET_VECTOR;
            bus.fifo_flush        <= 1'b1;
        end else if (src != SRC_NONE) begin
            state_q               <= ST_FLUSH;
            bus.pc_branch_valid   <= 1'b1;
            bus.pc_branch_address <= tgt;
            bus.fifo_flush        <= 1'b1;
        end else begin
            bus.pc_branch_valid <= 1'b0;
            bus.fifo_flush      <= 1'b0;
            case (state_q)
                ST_FLUSH: state_q <= ST_RUN;
                ST_RUN:   if (bus.halt_req) state_q <= ST_HALT;
                ST_HALT:  if (bus.resume_req) state_q <= ST_RUN;
                default:  state_q <= ST_BOOT;
            endcase
        end
    end

    fetch_credit_cnt #(.DEPTH(FIFO_DEPTH)) u_credit (
        .clk   (clk),
        .reset (reset),
        .clear (flush_d),
        .inc   (fetch_en),
        .dec   (bus.fifo_pop),
        .count (bus.occupancy),
        .full  (credit_full),
        .empty (credit_empty)
    );

    // Nothing is fetched while flushing, so the FIFO must stay empty there.
    flush_empty: assert property (@(posedge clk) disable iff (reset)
                                  (state_q == ST_FLUSH) |-> credit_empty);

`ifdef FETCH_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (src != SRC_NONE && redirect_cnt != 16'hFFFF)
                redirect_cnt <= redirect_cnt + 16'd1;
            if (state_q == ST_RUN && !fetch_en && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed vector bench for fetch_sequencer
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_sequencer_if #(.ADDR_W(11), .FIFO_DEPTH(8)) bus ();

`ifdef FETCH_SEQ_PERF_EN
    logic [15:0] redirect_cnt;
    logic [15:0] stall_cnt;
`endif

    fetch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        exc;
        logic        br;
        logic [10:0] bt;
        logic        jmp;
        logic [10:0] jt;
        logic        halt;
        logic        resume;
        logic        pop;
        logic [1:0]  st;
        logic        pbv;
        logic [10:0] addr;
        logic        flush;
        logic [3:0]  occ;
        logic        fe;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic exc, input logic br, input logic [10:0] bt,
                                input logic jmp, input logic [10:0] jt, input logic halt,
                                input logic resume, input logic pop, input logic [1:0] st,
                                input logic pbv, input logic [10:0] addr, input logic flush,
                                input logic [3:0] occ, input logic fe);
        vec_t v;
        v = '{exc, br, bt, jmp, jt, halt, resume, pop, st, pbv, addr, flush, occ, fe};
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.exc_valid  = v.exc;
        bus.br_valid   = v.br;
        bus.br_target  = v.bt;
        bus.jmp_valid  = v.jmp;
        bus.jmp_target = v.jt;
        bus.halt_req   = v.halt;
        bus.resume_req = v.resume;
        bus.fifo_pop   = v.pop;
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] st, input logic pbv,
                                 input logic [10:0] addr, input logic flush,
                                 input logic [3:0] occ, input logic fe);
        chk({tag, " state"}, int'(bus.state), int'(st));
        chk({tag, " pc_branch_valid"}, int'(bus.pc_branch_valid), int'(pbv));
        if (pbv) chk({tag, " pc_branch_address"}, int'(bus.pc_branch_address), int'(addr));
        chk({tag, " fifo_flush"}, int'(bus.fifo_flush), int'(flush));
        chk({tag, " occupancy"}, int'(bus.occupancy), int'(occ));
        chk({tag, " fetch_en"}, int'(bus.fetch_en), int'(fe));
        chk({tag, " pc_hold"}, int'(bus.pc_hold), int'(!fe));
    endtask

    initial begin
        // boot
        vq.push_back(mk(0,0,0,0,0,0,0,0, 2'd2,1,11'h000,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 2'd1,0,11'h000,0,0,1));
        // fill to depth 8
        for (int i = 1; i <= 8; i++)
            vq.push_back(mk(0,0,0,0,0,0,0,0, 2'd1,0,0,0,4'(i),(i < 8)));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 2'd1,0,0,0,8,0));
        vq.push_back(mk(0,0,0,0,0,0,0,1, 2'd1,0,0,0,7,1));
        vq.push_back(mk(0,0,0,0,0,0,0,1, 2'd1,0,0,0,7,1));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 2'd1,0,0,0,8,0));
        // simultaneous exc/br/jmp
        vq.push_back(mk(1,1,11'h123,1,11'h055,0,0,0, 2'd2,1,11'h7F0,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 2'd1,0,0,0,0,1));
        // back-to-back br then jmp during FLUSH
        vq.push_back(mk(0,1,11'h040,0,0,0,0,0, 2'd2,1,11'h040,1,0,0));
        vq.push_back(mk(0,0,0,1,11'h050,0,0,0, 2'd2,1,11'h050,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 2'd1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 2'd1,0,0,0,1,1));
        // pop on the flush edge is dropped
        vq.push_back(mk(0,0,0,1,11'h066,0,0,1, 2'd2,1,11'h066,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 2'd1,0,0,0,0,1));
        // halt: br/jmp ignored, exc wakes over resume
        vq.push_back(mk(0,0,0,0,0,1,0,0, 2'd3,0,0,0,1,0));
        vq.push_back(mk(0,1,11'h0AA,0,0,0,0,0, 2'd3,0,0,0,1,0));
        vq.push_back(mk(0,0,0,1,11'h0BB,0,0,0, 2'd3,0,0,0,1,0));
        vq.push_back(mk(0,0,0,0,0,0,0,1, 2'd3,0,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0,0,1,0, 2'd2,1,11'h7F0,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 2'd1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,1,0,0, 2'd3,0,0,0,1,0));
        vq.push_back(mk(0,0,0,0,0,0,1,0, 2'd1,0,0,0,1,1));
        // redirect beats halt; br beats jmp inside FLUSH
        vq.push_back(mk(0,1,11'h0CC,0,0,1,0,0, 2'd2,1,11'h0CC,1,0,0));
        vq.push_back(mk(0,1,11'h0DD,1,11'h0EE,0,0,0, 2'd2,1,11'h0DD,1,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0, 2'd1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,1,11'h100,0,0,0, 2'd2,1,11'h100,1,0,0));

        reset = 1'b1;
        drive('0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 2'd0, 0, 11'h000, 0, 0, 0);
        chk("reset addr", int'(bus.pc_branch_address), 0);
`ifdef FETCH_SEQ_PERF_EN
        chk("reset redirect_cnt", int'(redirect_cnt), 0);
        chk("reset stall_cnt", int'(stall_cnt), 0);
`endif
        reset = 1'b0;
        chk("boot state", int'(bus.state), 0);

        foreach (vq[i]) begin
            drive(vq[i]);
            @(posedge clk);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vq[i].st, vq[i].pbv, vq[i].addr,
                          vq[i].flush, vq[i].occ, vq[i].fe);
        end

`ifdef FETCH_SEQ_PERF_EN
        chk("perf redirect_cnt", int'(redirect_cnt), 8);
        chk("perf stall_cnt", int'(stall_cnt), 3);
`endif

        // reset while in FLUSH
        reset = 1'b1;
        drive('0);
        @(posedge clk);
        @(negedge clk);
        check_outputs("midflush reset", 2'd0, 0, 11'h000, 0, 0, 0);
        chk("midflush addr", int'(bus.pc_branch_address), 0);
`ifdef FETCH_SEQ_PERF_EN
        chk("midflush redirect_cnt", int'(redirect_cnt), 0);
`endif
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs("reboot", 2'd2, 1, 11'h000, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check_outputs("reboot run", 2'd1, 0, 11'h000, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
